reorder_buffer: RTL and testbench
=================================

// Module: reorder_buffer
// PURPOSE
//  Circular in-order retirement queue between issue, the CDB and the register file. Allocates a
//  nonzero RobId per issued instruction and captures results from the CDB. Retires at most one
//  entry per cycle as a registered commit_* pulse to the register file, and flags the
//  load/store buffer when a store retires. Detects a branch mispredict at retirement, flushes
//  all entries and drives jump_flag/jump_pc. RobId 0 means "no pending producer" and is never allocated.
// PARAMETERS
//  ROB_LOG   4   RobId width (`ROB_LOG); capacity ROB_SIZE = 2**ROB_LOG-1, ids 1..ROB_SIZE
// PORTS
//  clk                 in   1        clock, posedge
//  rst                 in   1        asynchronous reset, active-high
//  rdy                 in   1        global enable; 0 = freeze all state and outputs
//  issue_valid         in   1        allocate tail entry this cycle
//  issue_type          in   2        0 REG, 1 BRANCH, 2 STORE (3 reserved, treated as REG)
//  issue_rd            in   5        destination reg (0 = none)
//  issue_pred_jump     in   1        predicted taken (BRANCH only)
//  issue_RobId         out  ROB_LOG  id that the next allocation receives (= tail), comb
//  rob_full            out  1        count == ROB_SIZE, comb
//  cdb_valid           in   1        result broadcast
//  cdb_RobId           in   ROB_LOG  target entry
//  cdb_value           in   32       rd value (REG; BRANCH link value)
//  cdb_jump            in   1        actual taken (BRANCH)
//  cdb_target          in   32       correct next PC (BRANCH)
//  query_j_id/k_id     in   ROB_LOG  operand lookup ids
//  query_j_ready/k     out  1        entry done (or being written by CDB this cycle), comb
//  query_j_value/k     out  32       value of that entry / CDB bypass, comb
//  commit_valid        out  1        registered retire pulse for REG/BRANCH
//  commit_dest         out  5        rd of retired entry
//  commit_value        out  32       value of retired entry
//  commit_RobId        out  ROB_LOG  id of retired entry
//  store_commit_valid  out  1        registered pulse: STORE at head retired
//  store_commit_RobId  out  ROB_LOG  id of that store
//  jump_flag           out  1        registered flush pulse (mispredict)
//  jump_pc             out  32       redirect PC, valid with jump_flag
// BEHAVIOUR
//  - Reset (async): head=tail=1, count=0, all busy/ready cleared; every output reg 0.
//  - rdy=0: no state change; registered outputs hold. A pulse is therefore consumed exactly
//    once, at the first rdy=1 edge, and is cleared at that same edge.
//  - Pointer wrap: ROB_SIZE -> 1 (never 0). count 0..ROB_SIZE; empty when count==0.
//  - Issue: issue_valid && !rob_full && !jump_flag -> entry[tail] busy, not ready; tail advances.
//    Issue while full is dropped (issuer protocol violation, state unchanged).
//  - CDB: cdb_valid && entry busy -> store value/jump/target, ready=1. Becomes visible to
//    retirement next cycle; query ports see it the same cycle via bypass. CDB to non-busy id ignored.
//  - Retire (each rdy edge): if count>0 && entry[head].ready:
//      REG    -> commit_valid=1 with dest/value/RobId.
//      STORE  -> store_commit_valid=1, commit_valid=0.
//      BRANCH -> commit_valid=1 (dest may be 0). If cdb_jump != pred_jump: jump_flag=1,
//                jump_pc=target. At the same edge, flush: head=tail=1, count=0, all busy cleared.
//    Head advances; count decrements. Otherwise all pulses go to 0 at that edge.
//  - Simultaneous issue+retire: count unchanged; both take effect.
//  - Mispredict flush overrides issue and CDB in the same edge.
//  - Cycle with jump_flag=1: issue_valid and cdb_valid are ignored (other units are flushing).
//  - Latency: CDB write at edge N -> earliest commit_valid high after edge N+1.
//  - rob_full and issue_RobId are comb from registered count/tail; no dependence on same-cycle retire.
// TESTING
//  1 reset mid-stream with 5 busy entries -> count=0, issue_RobId=1, all pulses 0 without a clk edge.
//  2 issue REG rd=3, CDB id1 value 0xDEAD -> one-cycle commit_valid, dest=3, value=0xDEAD, RobId=1.
//  3 fill 15 entries -> rob_full=1; retire one -> tail ids wrap 15->1; the next id issued is 1, never 0.
//  4 BRANCH pred=0, cdb_jump=1, target 0x1000, 3 younger entries -> jump_flag=1, jump_pc=0x1000, count=0.
//  5 query_j_id=4 while cdb_RobId=4 value 7 -> query_j_ready=1, value=7 same cycle.
//  6 rdy=0 while commit_valid=1 -> held; after rdy=1 edge -> 0; STORE head -> store_commit_valid only.

Source files
------------

// File: rtl/reorder_buffer.sv
// In-order retirement queue: allocates nonzero RobIds, captures CDB results, retires one entry per cycle.
// Latency: CDB write at edge N is retireable at edge N+1; commit_*/jump_* are registered pulses.
// Backpressure: rob_full blocks issue (issue while full is dropped); rdy=0 freezes all state and outputs.
module reorder_buffer #(
  parameter int ROB_LOG = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               issue_valid,
  input  logic [1:0]         issue_type,
  input  logic [4:0]         issue_rd,
  input  logic               issue_pred_jump,
  output logic [ROB_LOG-1:0] issue_RobId,
  output logic               rob_full,
  input  logic               cdb_valid,
  input  logic [ROB_LOG-1:0] cdb_RobId,
  input  logic [31:0]        cdb_value,
  input  logic               cdb_jump,
  input  logic [31:0]        cdb_target,
  input  logic [ROB_LOG-1:0] query_j_id,
  input  logic [ROB_LOG-1:0] query_k_id,
  output logic               query_j_ready,
  output logic               query_k_ready,
  output logic [31:0]        query_j_value,
  output logic [31:0]        query_k_value,
  output logic               commit_valid,
  output logic [4:0]         commit_dest,
  output logic [31:0]        commit_value,
  output logic [ROB_LOG-1:0] commit_RobId,
  output logic               store_commit_valid,
  output logic [ROB_LOG-1:0] store_commit_RobId,
  output logic               jump_flag,
  output logic [31:0]        jump_pc
);

  localparam int DEPTH    = 2**ROB_LOG;
  localparam int ROB_SIZE = DEPTH - 1;
  localparam logic [ROB_LOG-1:0] ID_ONE  = ROB_LOG'(1);
  localparam logic [ROB_LOG-1:0] ID_LAST = ROB_LOG'(ROB_SIZE);
  localparam logic [1:0] TYPE_BRANCH = 2'd1;
  localparam logic [1:0] TYPE_STORE  = 2'd2;

  // Pointers and occupancy; slot 0 exists but is never allocated, so busy[0] stays 0.
  logic [ROB_LOG-1:0] head, tail, count;
  logic [DEPTH-1:0]   busy, done;

  // Per-entry payload, written only on allocation / CDB capture.
  logic [1:0]  e_type   [DEPTH];
  logic [4:0]  e_rd     [DEPTH];
  logic        e_pred   [DEPTH];
  logic [31:0] e_value  [DEPTH];
  logic        e_jump   [DEPTH];
  logic [31:0] e_target [DEPTH];

  logic issue_fire, cdb_fire, retire_fire, head_is_store, mispredict;

  function automatic logic [ROB_LOG-1:0] next_id(input logic [ROB_LOG-1:0] id);
    return (id == ID_LAST) ? ID_ONE : id + ID_ONE;
  endfunction

  assign issue_RobId = tail;
  assign rob_full    = (count == ID_LAST);

  // While jump_flag is up the rest of the machine is flushing, so its issue/CDB traffic is stale.
  assign issue_fire    = issue_valid && !rob_full && !jump_flag;
  assign cdb_fire      = cdb_valid && busy[cdb_RobId] && !jump_flag;
  assign retire_fire   = (count != '0) && done[head];
  assign head_is_store = (e_type[head] == TYPE_STORE);
  assign mispredict    = retire_fire && (e_type[head] == TYPE_BRANCH) &&
                         (e_jump[head] != e_pred[head]);

  // Operand lookup with same-cycle CDB bypass.
  assign query_j_ready = (cdb_fire && cdb_RobId == query_j_id) ||
                         (busy[query_j_id] && done[query_j_id]);
  assign query_k_ready = (cdb_fire && cdb_RobId == query_k_id) ||
                         (busy[query_k_id] && done[query_k_id]);
  assign query_j_value = (cdb_fire && cdb_RobId == query_j_id) ? cdb_value : e_value[query_j_id];
  assign query_k_value = (cdb_fire && cdb_RobId == query_k_id) ? cdb_value : e_value[query_k_id];

  // Control state: allocation, completion, retirement, mispredict flush and the registered pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head               <= ID_ONE;
      tail               <= ID_ONE;
      count              <= '0;
      busy               <= '0;
      done               <= '0;
      commit_valid       <= 1'b0;
      commit_dest        <= '0;
      commit_value       <= '0;
      commit_RobId       <= '0;
      store_commit_valid <= 1'b0;
      store_commit_RobId <= '0;
      jump_flag          <= 1'b0;
      jump_pc            <= '0;
    end else if (rdy) begin
      commit_valid       <= 1'b0;
      store_commit_valid <= 1'b0;
      jump_flag          <= 1'b0;

      if (cdb_fire) done[cdb_RobId] <= 1'b1;

      // Issue and retire never touch the same slot: that needs count 0 (no retire) or full (no issue).
      if (issue_fire) begin
        busy[tail] <= 1'b1;
        done[tail] <= 1'b0;
        tail       <= next_id(tail);
      end

      // Retire clears the slot after any same-edge CDB write to it, so the late result is discarded.
      if (retire_fire) begin
        busy[head] <= 1'b0;
        done[head] <= 1'b0;
        head       <= next_id(head);
        if (head_is_store) begin
          store_commit_valid <= 1'b1;
          store_commit_RobId <= head;
        end else begin
          commit_valid <= 1'b1;
          commit_dest  <= e_rd[head];
          commit_value <= e_value[head];
          commit_RobId <= head;
        end
        if (mispredict) begin
          jump_flag <= 1'b1;
          jump_pc   <= e_target[head];
        end
      end

      if (issue_fire && !retire_fire)      count <= count + ID_ONE;
      else if (!issue_fire && retire_fire) count <= count - ID_ONE;

      // Mispredict flush wins over everything above.
      if (mispredict) begin
        head  <= ID_ONE;
        tail  <= ID_ONE;
        count <= '0;
        busy  <= '0;
        done  <= '0;
      end
    end
  end

  // Entry payload capture; validity is tracked by busy/done so no reset is needed here.
  always_ff @(posedge clk) begin
    if (rdy && issue_fire) begin
      e_type[tail] <= issue_type;
      e_rd[tail]   <= issue_rd;
      e_pred[tail] <= issue_pred_jump;
    end
    if (rdy && cdb_fire) begin
      e_value[cdb_RobId]  <= cdb_value;
      e_jump[cdb_RobId]   <= cdb_jump;
      e_target[cdb_RobId] <= cdb_target;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst, rdy, issue_valid, issue_pred_jump;
  logic [1:0]  issue_type;
  logic [4:0]  issue_rd;
  logic [3:0]  issue_RobId;
  logic        rob_full;
  logic        cdb_valid, cdb_jump;
  logic [3:0]  cdb_RobId;
  logic [31:0] cdb_value, cdb_target;
  logic [3:0]  query_j_id, query_k_id;
  logic        query_j_ready, query_k_ready;
  logic [31:0] query_j_value, query_k_value;
  logic        commit_valid;
  logic [4:0]  commit_dest;
  logic [31:0] commit_value;
  logic [3:0]  commit_RobId;
  logic        store_commit_valid;
  logic [3:0]  store_commit_RobId;
  logic        jump_flag;
  logic [31:0] jump_pc;

  reorder_buffer #(.ROB_LOG(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
    .issue_pred_jump(issue_pred_jump), .issue_RobId(issue_RobId), .rob_full(rob_full),
    .cdb_valid(cdb_valid), .cdb_RobId(cdb_RobId), .cdb_value(cdb_value),
    .cdb_jump(cdb_jump), .cdb_target(cdb_target),
    .query_j_id(query_j_id), .query_k_id(query_k_id),
    .query_j_ready(query_j_ready), .query_k_ready(query_k_ready),
    .query_j_value(query_j_value), .query_k_value(query_k_value),
    .commit_valid(commit_valid), .commit_dest(commit_dest), .commit_value(commit_value),
    .commit_RobId(commit_RobId), .store_commit_valid(store_commit_valid),
    .store_commit_RobId(store_commit_RobId), .jump_flag(jump_flag), .jump_pc(jump_pc)
  );

  always #5 clk = ~clk;

  // Reference model: the ROB is simply an ordered list of in-flight instructions.
  typedef struct {
    int          id;
    logic [1:0]  ty;
    logic [4:0]  rd;
    logic        pred;
    logic        done;
    logic [31:0] val;
    logic        jmp;
    logic [31:0] tgt;
  } ent_t;

  ent_t        mq[$];
  int          m_tail;
  logic        e_cv, e_sv, e_jf;
  logic [4:0]  e_cd;
  logic [31:0] e_cval, e_jpc;
  int          e_cid, e_sid;

  int          nvec = 0;
  int          nerr = 0;
  logic        last_qj_rdy;
  logic [31:0] last_qj_val;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int find_id(input int id);
    foreach (mq[i]) if (mq[i].id == id) return i;
    return -1;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_tail = 1;
    e_cv = 0; e_sv = 0; e_jf = 0;
    e_cd = 0; e_cval = 0; e_jpc = 0; e_cid = 0; e_sid = 0;
  endtask

  task automatic model_query(input int id, output logic r, output logic [31:0] v);
    int i;
    i = find_id(id);
    r = 0; v = 0;
    if (cdb_valid && !e_jf && i >= 0 && int'(cdb_RobId) == id) begin
      r = 1; v = cdb_value;
    end else if (i >= 0 && mq[i].done) begin
      r = 1; v = mq[i].val;
    end
  endtask

  // One enabled clock edge, applied to the list from the pre-edge state and current inputs.
  task automatic model_edge();
    bit   pre_full, pre_jf, flush;
    ent_t h, n;
    int   i;
    pre_full = (mq.size() == 15);
    pre_jf   = e_jf;
    flush    = 0;
    e_cv = 0; e_sv = 0; e_jf = 0;
    if (mq.size() > 0 && mq[0].done) begin
      h = mq.pop_front();
      if (h.ty == 2) begin
        e_sv = 1; e_sid = h.id;
      end else begin
        e_cv = 1; e_cd = h.rd; e_cval = h.val; e_cid = h.id;
        if (h.ty == 1 && h.jmp != h.pred) begin
          e_jf = 1; e_jpc = h.tgt; flush = 1;
        end
      end
    end
    if (flush) begin
      mq.delete();
      m_tail = 1;
    end else begin
      if (cdb_valid && !pre_jf) begin
        i = find_id(int'(cdb_RobId));
        if (i >= 0) begin
          mq[i].done = 1; mq[i].val = cdb_value; mq[i].jmp = cdb_jump; mq[i].tgt = cdb_target;
        end
      end
      if (issue_valid && !pre_full && !pre_jf) begin
        n.id = m_tail; n.ty = issue_type; n.rd = issue_rd; n.pred = issue_pred_jump;
        n.done = 0; n.val = 0; n.jmp = 0; n.tgt = 0;
        mq.push_back(n);
        m_tail = (m_tail == 15) ? 1 : m_tail + 1;
      end
    end
  endtask

  // Compare process for one cycle: comb outputs before the edge, registered outputs after it.
  task automatic cycle();
    logic        r;
    logic [31:0] v;
    #1;
    chk("issue_RobId", 32'(issue_RobId), 32'(m_tail));
    chk("rob_full", 32'(rob_full), 32'(mq.size() == 15));
    if (rdy) begin
      model_query(int'(query_j_id), r, v);
      chk("query_j_ready", 32'(query_j_ready), 32'(r));
      if (r) chk("query_j_value", query_j_value, v);
      model_query(int'(query_k_id), r, v);
      chk("query_k_ready", 32'(query_k_ready), 32'(r));
      if (r) chk("query_k_value", query_k_value, v);
      last_qj_rdy = query_j_ready;
      last_qj_val = query_j_value;
      model_edge();
    end
    @(posedge clk);
    #1;
    chk("commit_valid", 32'(commit_valid), 32'(e_cv));
    if (e_cv) begin
      chk("commit_dest", 32'(commit_dest), 32'(e_cd));
      chk("commit_value", commit_value, e_cval);
      chk("commit_RobId", 32'(commit_RobId), 32'(e_cid));
    end
    chk("store_commit_valid", 32'(store_commit_valid), 32'(e_sv));
    if (e_sv) chk("store_commit_RobId", 32'(store_commit_RobId), 32'(e_sid));
    chk("jump_flag", 32'(jump_flag), 32'(e_jf));
    if (e_jf) chk("jump_pc", jump_pc, e_jpc);
    @(negedge clk);
  endtask

  task automatic idle_in();
    rdy = 1; issue_valid = 0; issue_type = 0; issue_rd = 0; issue_pred_jump = 0;
    cdb_valid = 0; cdb_RobId = 0; cdb_value = 0; cdb_jump = 0; cdb_target = 0;
    query_j_id = 0; query_k_id = 0;
  endtask

  task automatic reset_outputs_chk(input string tag);
    chk({tag, "_issue_RobId"}, 32'(issue_RobId), 32'd1);
    chk({tag, "_rob_full"}, 32'(rob_full), 32'd0);
    chk({tag, "_commit_valid"}, 32'(commit_valid), 32'd0);
    chk({tag, "_commit_value"}, commit_value, 32'd0);
    chk({tag, "_store_commit_valid"}, 32'(store_commit_valid), 32'd0);
    chk({tag, "_jump_flag"}, 32'(jump_flag), 32'd0);
    chk({tag, "_jump_pc"}, jump_pc, 32'd0);
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1;
    #2;
    model_reset();
    reset_outputs_chk("reset");
    @(negedge clk);
    rst = 0;
  endtask

  task automatic issue_one(input logic [1:0] ty, input logic [4:0] rd, input logic pred);
    idle_in();
    issue_valid = 1; issue_type = ty; issue_rd = rd; issue_pred_jump = pred;
    cycle();
  endtask

  task automatic cdb_one(input logic [3:0] id, input logic [31:0] val, input logic j,
                         input logic [31:0] tgt);
    idle_in();
    cdb_valid = 1; cdb_RobId = id; cdb_value = val; cdb_jump = j; cdb_target = tgt;
    cycle();
  endtask

  initial begin
    rst = 1;
    idle_in();
    model_reset();
    @(negedge clk);
    do_reset();

    // Reset mid-stream with busy entries and a live commit pulse.
    for (int i = 0; i < 5; i++) issue_one(2'd0, 5'(i + 1), 1'b0);
    cdb_one(4'd1, 32'h11, 1'b0, 32'h0);
    idle_in(); cycle();
    chk("t1_commit_before_reset", 32'(commit_valid), 32'd1);
    rst = 1;
    #2;
    model_reset();
    reset_outputs_chk("t1_async");
    @(negedge clk);
    rst = 0;

    // Single REG instruction through to commit.
    issue_one(2'd0, 5'd3, 1'b0);
    cdb_one(4'd1, 32'hDEAD, 1'b0, 32'h0);
    idle_in(); cycle();
    chk("t2_commit_valid", 32'(commit_valid), 32'd1);
    chk("t2_commit_dest", 32'(commit_dest), 32'd3);
    chk("t2_commit_value", commit_value, 32'hDEAD);
    chk("t2_commit_RobId", 32'(commit_RobId), 32'd1);
    idle_in(); cycle();
    chk("t2_pulse_drop", 32'(commit_valid), 32'd0);

    // Fill to capacity, drop an over-issue, then wrap the tail back to id 1.
    do_reset();
    for (int i = 0; i < 15; i++) issue_one(2'd0, 5'd7, 1'b0);
    chk("t3_full", 32'(rob_full), 32'd1);
    chk("t3_tail_wrapped", 32'(issue_RobId), 32'd1);
    issue_one(2'd0, 5'd9, 1'b0);
    chk("t3_drop_keeps_tail", 32'(issue_RobId), 32'd1);
    cdb_one(4'd1, 32'h55, 1'b0, 32'h0);
    idle_in(); cycle();
    chk("t3_retire_id1", 32'(commit_RobId), 32'd1);
    chk("t3_not_full", 32'(rob_full), 32'd0);
    issue_one(2'd0, 5'd8, 1'b0);
    chk("t3_next_tail", 32'(issue_RobId), 32'd2);
    chk("t3_full_again", 32'(rob_full), 32'd1);

    // Branch mispredict with younger entries behind it.
    do_reset();
    issue_one(2'd1, 5'd1, 1'b0);
    for (int i = 0; i < 3; i++) issue_one(2'd0, 5'(i + 4), 1'b0);
    cdb_one(4'd1, 32'h4, 1'b1, 32'h1000);
    idle_in(); cycle();
    chk("t4_jump_flag", 32'(jump_flag), 32'd1);
    chk("t4_jump_pc", jump_pc, 32'h1000);
    chk("t4_flushed_tail", 32'(issue_RobId), 32'd1);
    issue_one(2'd0, 5'd2, 1'b0);
    chk("t4_issue_ignored", 32'(issue_RobId), 32'd1);
    chk("t4_jump_drop", 32'(jump_flag), 32'd0);

    // CDB bypass to the query port.
    do_reset();
    for (int i = 0; i < 4; i++) issue_one(2'd0, 5'(i + 1), 1'b0);
    idle_in();
    cdb_valid = 1; cdb_RobId = 4'd4; cdb_value = 32'd7; query_j_id = 4'd4; query_k_id = 4'd1;
    cycle();
    chk("t5_bypass_ready", 32'(last_qj_rdy), 32'd1);
    chk("t5_bypass_value", last_qj_val, 32'd7);

    // rdy=0 holds a pulse; store retires on its own pulse.
    do_reset();
    issue_one(2'd0, 5'd6, 1'b0);
    cdb_one(4'd1, 32'h66, 1'b0, 32'h0);
    idle_in(); cycle();
    idle_in(); rdy = 0; issue_valid = 1; cycle();
    idle_in(); rdy = 0; cycle();
    chk("t6_held", 32'(commit_valid), 32'd1);
    chk("t6_held_tail", 32'(issue_RobId), 32'd2);
    idle_in(); cycle();
    chk("t6_released", 32'(commit_valid), 32'd0);
    issue_one(2'd2, 5'd0, 1'b0);
    cdb_one(4'd2, 32'h0, 1'b0, 32'h0);
    idle_in(); cycle();
    chk("t6_store_valid", 32'(store_commit_valid), 32'd1);
    chk("t6_store_id", 32'(store_commit_RobId), 32'd2);
    chk("t6_store_no_commit", 32'(commit_valid), 32'd0);

    // Randomized traffic alternating between filling and draining phases.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      bit fill;
      int pend[$];
      int pick;
      fill = ((c / 150) % 2) == 0;
      idle_in();
      rdy             = ($urandom_range(0, 7) != 0);
      issue_valid     = ($urandom_range(0, 99) < (fill ? 85 : 35));
      issue_type      = 2'($urandom_range(0, 3));
      issue_rd        = 5'($urandom_range(0, 31));
      issue_pred_jump = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) < (fill ? 25 : 70)) begin
        cdb_valid  = 1;
        cdb_value  = $urandom;
        cdb_target = $urandom;
        cdb_jump   = 1'($urandom_range(0, 1));
        pend.delete();
        foreach (mq[i]) if (!mq[i].done) pend.push_back(i);
        if (pend.size() > 0 && $urandom_range(0, 9) != 0) begin
          pick      = pend[$urandom_range(0, pend.size() - 1)];
          cdb_RobId = 4'(mq[pick].id);
          if (mq[pick].ty == 2'd1)
            cdb_jump = ($urandom_range(0, 5) == 0) ? !mq[pick].pred : mq[pick].pred;
        end else begin
          cdb_RobId = 4'($urandom_range(0, 15));
        end
      end
      query_j_id = (cdb_valid && $urandom_range(0, 1) == 1) ? cdb_RobId : 4'($urandom_range(0, 15));
      query_k_id = 4'($urandom_range(0, 15));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
